// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the RamIO port-B arbiter.
//   state_e        FSM encoding (IDLE / BUSY / DONE)
//   DEF_RAM_BASE   default byte address of RAM word 0
//   DEF_RAM_BYTES  default RAM size in bytes
//   REQ_CORE       requester index of the core load/store unit
//   REQ_LOADER     requester index of the boot/debug loader
package ram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [31:0] DEF_RAM_BASE  = 32'h8000_0000;
   localparam int unsigned DEF_RAM_BYTES = 65536;

   localparam logic REQ_CORE   = 1'b0;
   localparam logic REQ_LOADER = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick.
//   clk, rst        clock, synchronous active-high reset
//   en_i            evaluate requests this cycle (arbiter FSM in IDLE)
//   req_i[1:0]      request lines, bit index = requester index
//   gnt_vld_o       a grant is issued this cycle
//   gnt_idx_o       index of the granted requester
// On a tie the requester that did not win last time is chosen. The history
// register follows every grant, so a lone requester also hands priority to
// the other one for the next tie.
module rr_arbiter2
   import ram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic       gnt_vld_o,
   output logic       gnt_idx_o
);

   logic last_grant_q;

   always_comb begin
      gnt_vld_o = en_i & (|req_i);
      unique case (req_i)
         2'b10:   gnt_idx_o = REQ_LOADER;
         2'b11:   gnt_idx_o = ~last_grant_q;
         default: gnt_idx_o = REQ_CORE;
      endcase
   end

   // Reset to the loader so the core wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= REQ_LOADER;
      end else if (gnt_vld_o) begin
         last_grant_q <= gnt_idx_o;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares RamIO port B between the core LSU (m0) and the
// boot/debug loader (m1). One request is granted at a time, its fields are
// latched, range/alignment are checked, and the RAM request is held until
// ram_requestDone or a timeout. The winner gets a one-cycle requestDone,
// qualified by fault for rejected/aborted requests.
//   clk, rst                       clock, synchronous active-high reset
//   mX_addr/din/we/isRequest       requester X request fields (X = 0, 1)
//   mX_dout/requestDone/fault      requester X response
//   ram_addr/din/we/isRequest      request to RamIO port B
//   ram_dout/requestDone           response from RamIO port B
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
   parameter int unsigned RAM_BYTES = DEF_RAM_BYTES,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_din,
   input  logic [3:0]  m0_we,
   input  logic        m0_isRequest,
   output logic [31:0] m0_dout,
   output logic        m0_requestDone,
   output logic        m0_fault,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_din,
   input  logic [3:0]  m1_we,
   input  logic        m1_isRequest,
   output logic [31:0] m1_dout,
   output logic        m1_requestDone,
   output logic        m1_fault,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_din,
   output logic [3:0]  ram_we,
   output logic        ram_isRequest,
   input  logic [31:0] ram_dout,
   input  logic        ram_requestDone
);

   state_e      state_q, state_d;
   logic        gnt_vld, gnt_idx;
   logic        gnt_q, fault_q;
   logic [7:0]  cnt_q;
   logic [31:0] addr_q, din_q, dout_q;
   logic [3:0]  we_q;
   logic [31:0] req_addr, req_din, req_off;
   logic [3:0]  req_we;
   logic        req_legal, timeout, busy, done;

   rr_arbiter2 u_rr (
      .clk       (clk),
      .rst       (rst),
      .en_i      (state_q == ST_IDLE),
      .req_i     ({m1_isRequest, m0_isRequest}),
      .gnt_vld_o (gnt_vld),
      .gnt_idx_o (gnt_idx)
   );

   // Legality is evaluated on the fields being latched this edge, so the
   // IDLE decision can branch straight to BUSY or to a fault DONE.
   always_comb begin
      req_addr  = (gnt_idx == REQ_LOADER) ? m1_addr : m0_addr;
      req_din   = (gnt_idx == REQ_LOADER) ? m1_din  : m0_din;
      req_we    = (gnt_idx == REQ_LOADER) ? m1_we   : m0_we;
      req_off   = req_addr - RAM_BASE;
      req_legal = (req_addr >= RAM_BASE) && (req_off < 32'(RAM_BYTES)) &&
                  (req_addr[1:0] == 2'b00);
   end

   // cnt_q counts completed BUSY cycles, so BUSY lasts at most TIMEOUT cycles.
   assign timeout = (state_q == ST_BUSY) && (cnt_q == 8'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (gnt_vld) state_d = req_legal ? ST_BUSY : ST_DONE;
         ST_BUSY: if (ram_requestDone || timeout) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q   <= REQ_CORE;
         fault_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: if (gnt_vld) begin
               gnt_q   <= gnt_idx;
               fault_q <= ~req_legal;
               cnt_q   <= '0;
            end
            ST_BUSY: begin
               cnt_q <= cnt_q + 8'd1;
               if (ram_requestDone) fault_q <= 1'b0;
               else if (timeout)    fault_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Request/response data; only observed when qualified by the FSM.
   always_ff @(posedge clk) begin
      if (state_q == ST_IDLE && gnt_vld) begin
         addr_q <= req_addr;
         din_q  <= req_din;
         we_q   <= req_we;
         dout_q <= '0;
      end else if (state_q == ST_BUSY && ram_requestDone) begin
         dout_q <= (we_q == 4'h0) ? ram_dout : '0;
      end
   end

   always_comb begin
      busy           = (state_q == ST_BUSY);
      done           = (state_q == ST_DONE);
      ram_isRequest  = busy;
      ram_addr       = busy ? addr_q : '0;
      ram_din        = busy ? din_q  : '0;
      ram_we         = busy ? we_q   : '0;
      m0_requestDone = done && (gnt_q == REQ_CORE);
      m1_requestDone = done && (gnt_q == REQ_LOADER);
      m0_fault       = m0_requestDone & fault_q;
      m1_fault       = m1_requestDone & fault_q;
      m0_dout        = m0_requestDone ? dout_q : '0;
      m1_dout        = m1_requestDone ? dout_q : '0;
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m0_addr, m0_din, m0_dout;
   logic [3:0]  m0_we;
   logic        m0_isRequest, m0_requestDone, m0_fault;
   logic [31:0] m1_addr, m1_din, m1_dout;
   logic [3:0]  m1_we;
   logic        m1_isRequest, m1_requestDone, m1_fault;
   logic [31:0] ram_addr, ram_din, ram_dout;
   logic [3:0]  ram_we;
   logic        ram_isRequest, ram_requestDone;
   logic        resp_en;
   logic [31:0] mem [16];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.RAM_BASE(32'h8000_0000), .RAM_BYTES(65536), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .m0_addr(m0_addr), .m0_din(m0_din), .m0_we(m0_we), .m0_isRequest(m0_isRequest),
      .m0_dout(m0_dout), .m0_requestDone(m0_requestDone), .m0_fault(m0_fault),
      .m1_addr(m1_addr), .m1_din(m1_din), .m1_we(m1_we), .m1_isRequest(m1_isRequest),
      .m1_dout(m1_dout), .m1_requestDone(m1_requestDone), .m1_fault(m1_fault),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_isRequest(ram_isRequest),
      .ram_dout(ram_dout), .ram_requestDone(ram_requestDone)
   );

   // Small RAM model answering in the same cycle the request is presented.
   assign ram_requestDone = resp_en & ram_isRequest;
   assign ram_dout        = mem[ram_addr[5:2]];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
         mem[0] <= 32'hDEAD_BEEF;
         mem[2] <= 32'hCAFE_0002;
      end else if (ram_isRequest && ram_requestDone) begin
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_addr[5:2]][8*b +: 8] <= ram_din[8*b +: 8];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic req0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      m0_addr = a; m0_din = d; m0_we = w; m0_isRequest = 1'b1;
   endtask

   task automatic req1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      m1_addr = a; m1_din = d; m1_we = w; m1_isRequest = 1'b1;
   endtask

   initial begin
      rst = 1'b1; resp_en = 1'b1;
      m0_addr = '0; m0_din = '0; m0_we = '0; m0_isRequest = 1'b0;
      m1_addr = '0; m1_din = '0; m1_we = '0; m1_isRequest = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // Reset state
      chk("rst_ram_isRequest", 32'(ram_isRequest), 32'h0);
      chk("rst_ram_addr", ram_addr, 32'h0);
      chk("rst_ram_din", ram_din, 32'h0);
      chk("rst_ram_we", 32'(ram_we), 32'h0);
      chk("rst_m0_done", 32'(m0_requestDone), 32'h0);
      chk("rst_m1_done", 32'(m1_requestDone), 32'h0);
      chk("rst_m0_dout", m0_dout, 32'h0);
      chk("rst_m1_fault", 32'(m1_fault), 32'h0);

      // Read by m0, done returned during the first BUSY cycle
      req0(32'h8000_0000, 32'h0, 4'h0);
      tick();
      chk("rd_c1_isReq", 32'(ram_isRequest), 32'h1);
      chk("rd_c1_addr", ram_addr, 32'h8000_0000);
      chk("rd_c1_nodone", 32'(m0_requestDone), 32'h0);
      tick();
      chk("rd_c2_done", 32'(m0_requestDone), 32'h1);
      chk("rd_c2_dout", m0_dout, 32'hDEAD_BEEF);
      chk("rd_c2_fault", 32'(m0_fault), 32'h0);
      chk("rd_c2_m1quiet", 32'(m1_requestDone), 32'h0);
      chk("rd_c2_isReq", 32'(ram_isRequest), 32'h0);
      m0_isRequest = 1'b0;
      tick();
      chk("rd_c3_idle", 32'(m0_requestDone), 32'h0);

      // Byte write by m1 then read back
      req1(32'h8000_0004, 32'h1234_5678, 4'h3);
      tick();
      chk("wr_c1_we", 32'(ram_we), 32'h3);
      chk("wr_c1_din", ram_din, 32'h1234_5678);
      chk("wr_c1_addr", ram_addr, 32'h8000_0004);
      tick();
      chk("wr_c2_done", 32'(m1_requestDone), 32'h1);
      chk("wr_c2_dout", m1_dout, 32'h0);
      chk("wr_c2_fault", 32'(m1_fault), 32'h0);
      chk("wr_c2_m0quiet", 32'(m0_requestDone), 32'h0);
      m1_isRequest = 1'b0;
      tick();
      req1(32'h8000_0004, 32'h0, 4'h0);
      tick(); tick();
      chk("wrrd_done", 32'(m1_requestDone), 32'h1);
      chk("wrrd_dout", m1_dout, 32'h0000_5678);
      m1_isRequest = 1'b0;
      tick();

      // Tie: both always active, grants alternate m0, m1, m0, m1
      rst = 1'b1; tick(); rst = 1'b0;
      req0(32'h8000_0000, 32'h0, 4'h0);
      req1(32'h8000_0008, 32'h0, 4'h0);
      for (int t = 0; t < 4; t++) begin
         tick();
         chk($sformatf("tie%0d_addr", t), ram_addr, (t % 2 == 0) ? 32'h8000_0000 : 32'h8000_0008);
         chk($sformatf("tie%0d_busy_nodone", t), 32'({m1_requestDone, m0_requestDone}), 32'h0);
         tick();
         chk($sformatf("tie%0d_m0done", t), 32'(m0_requestDone), (t % 2 == 0) ? 32'h1 : 32'h0);
         chk($sformatf("tie%0d_m1done", t), 32'(m1_requestDone), (t % 2 == 1) ? 32'h1 : 32'h0);
         chk($sformatf("tie%0d_dout", t), (t % 2 == 0) ? m0_dout : m1_dout,
             (t % 2 == 0) ? 32'hDEAD_BEEF : 32'hCAFE_0002);
         tick();
         chk($sformatf("tie%0d_idle", t), 32'({m1_requestDone, m0_requestDone, ram_isRequest}), 32'h0);
      end
      m0_isRequest = 1'b0; m1_isRequest = 1'b0;
      tick();
      chk("tie_end_isReq", 32'(ram_isRequest), 32'h0);

      // Illegal addresses: below base, misaligned, one past the end
      for (int k = 0; k < 3; k++) begin
         case (k)
            0: req0(32'h7FFF_FFFC, 32'h0, 4'h0);
            1: req0(32'h8000_0002, 32'h0, 4'h0);
            default: req0(32'h8001_0000, 32'hFFFF_FFFF, 4'hF);
         endcase
         tick();
         chk($sformatf("ill%0d_done", k), 32'(m0_requestDone), 32'h1);
         chk($sformatf("ill%0d_fault", k), 32'(m0_fault), 32'h1);
         chk($sformatf("ill%0d_dout", k), m0_dout, 32'h0);
         chk($sformatf("ill%0d_isReq", k), 32'(ram_isRequest), 32'h0);
         m0_isRequest = 1'b0;
         tick();
         chk($sformatf("ill%0d_idle", k), 32'({m0_requestDone, ram_isRequest}), 32'h0);
      end

      // Last legal word
      req0(32'h8000_FFFC, 32'h0, 4'h0);
      tick();
      chk("top_isReq", 32'(ram_isRequest), 32'h1);
      tick();
      chk("top_done", 32'(m0_requestDone), 32'h1);
      chk("top_fault", 32'(m0_fault), 32'h0);
      m0_isRequest = 1'b0;
      tick();

      // Timeout (TIMEOUT=4): BUSY cycles 1..4, fault pulse at cycle 5
      resp_en = 1'b0;
      req0(32'h8000_0000, 32'h0, 4'h0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk($sformatf("to_c%0d_isReq", c), 32'(ram_isRequest), 32'h1);
         chk($sformatf("to_c%0d_nodone", c), 32'(m0_requestDone), 32'h0);
      end
      tick();
      chk("to_c5_done", 32'(m0_requestDone), 32'h1);
      chk("to_c5_fault", 32'(m0_fault), 32'h1);
      chk("to_c5_dout", m0_dout, 32'h0);
      chk("to_c5_isReq", 32'(ram_isRequest), 32'h0);
      m0_isRequest = 1'b0;
      tick();
      resp_en = 1'b1;
      req0(32'h8000_0000, 32'h0, 4'h0);
      tick(); tick();
      chk("to_after_done", 32'(m0_requestDone), 32'h1);
      chk("to_after_fault", 32'(m0_fault), 32'h0);
      chk("to_after_dout", m0_dout, 32'hDEAD_BEEF);
      m0_isRequest = 1'b0;
      tick();

      // Reset in BUSY during an m0 read
      resp_en = 1'b0;
      req0(32'h8000_0000, 32'h0, 4'h0);
      tick(); tick();
      chk("rb_c2_isReq", 32'(ram_isRequest), 32'h1);
      rst = 1'b1; m0_isRequest = 1'b0;
      tick();
      rst = 1'b0;
      chk("rb_isReq", 32'(ram_isRequest), 32'h0);
      chk("rb_addr", ram_addr, 32'h0);
      chk("rb_nodone", 32'({m1_requestDone, m0_requestDone, m0_fault}), 32'h0);
      tick();
      chk("rb_nodone2", 32'({m1_requestDone, m0_requestDone, m0_fault}), 32'h0);
      resp_en = 1'b1;
      req0(32'h8000_0000, 32'h0, 4'h0);
      req1(32'h8000_0008, 32'h0, 4'h0);
      tick();
      chk("rb_tie_addr", ram_addr, 32'h8000_0000);
      tick();
      chk("rb_tie_m0done", 32'(m0_requestDone), 32'h1);
      chk("rb_tie_m1quiet", 32'(m1_requestDone), 32'h0);
      m0_isRequest = 1'b0; m1_isRequest = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
